// File: rtl/seq_rf_wb_arb_scoreboard.sv
// seq_rf_wb_arb_scoreboard
// Writeback arbiter and per-register pending-bit scoreboard sitting in front of
// an 8 x 8-bit register file (1 write port, 2 read ports, register 0 reads as 0).
// Two writeback requesters share the single write port; two read-port operand
// checks report whether their register is still waiting on a producer.
//
// Build option: define SEQ_RF_WB_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on a conflict. Without it, requester 0 always wins a conflict and no priority
// pointer exists.
//
// Handshake: a requester raises wbN_val with wbN_addr/wbN_data and keeps all
// three stable until it sees wbN_rdy high; the writeback transfers in the
// cycle where val && rdy. rdy is combinational and may depend on the other
// requester's val. During reset rdy is held low, so nothing is accepted and
// the requester simply keeps retrying.
module seq_rf_wb_arb_scoreboard (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alloc_en,
  input  logic [2:0] alloc_addr,
  input  logic       wb0_val,
  output logic       wb0_rdy,
  input  logic [2:0] wb0_addr,
  input  logic [7:0] wb0_data,
  input  logic       wb1_val,
  output logic       wb1_rdy,
  input  logic [2:0] wb1_addr,
  input  logic [7:0] wb1_data,
  output logic       write_en,
  output logic [2:0] write_addr,
  output logic [7:0] write_data,
  input  logic [2:0] check_addr0,
  output logic       check_stall0,
  input  logic [2:0] check_addr1,
  output logic       check_stall1
);

  // One bit per register: set while a producer is outstanding.
  logic [7:0] pending;
  logic [7:0] pending_nxt;

  logic       grant0;
  logic       grant1;
  logic       any_grant;
  logic [2:0] sel_addr;
  logic [7:0] sel_data;

`ifdef SEQ_RF_WB_ARB_ROUND_ROBIN_EN
  // Index of the requester that wins the next conflict.
  logic       ptr;
`endif

  // Arbitration: a lone requester always wins; a conflict goes to the
  // priority holder. Nothing is granted while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (wb0_val && wb1_val) begin
`ifdef SEQ_RF_WB_ARB_ROUND_ROBIN_EN
        grant0 = ~ptr;
        grant1 = ptr;
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = wb0_val;
        grant1 = wb1_val;
      end
    end
  end

  assign wb0_rdy   = grant0;
  assign wb1_rdy   = grant1;
  assign any_grant = grant0 | grant1;

  // Write-port mux: the granted requester's address/data, zero when idle.
  always_comb begin
    sel_addr = 3'd0;
    sel_data = 8'd0;
    if (grant0) begin
      sel_addr = wb0_addr;
      sel_data = wb0_data;
    end else if (grant1) begin
      sel_addr = wb1_addr;
      sel_data = wb1_data;
    end
  end

  // Register 0 is hardwired, so a writeback there is accepted but dropped.
  assign write_en   = any_grant && (sel_addr != 3'd0);
  assign write_addr = sel_addr;
  assign write_data = sel_data;

  // Scoreboard next state: writeback clears, allocation sets and wins a tie.
  always_comb begin
    pending_nxt = pending;
    if (any_grant) begin
      pending_nxt[sel_addr] = 1'b0;
    end
    if (alloc_en && (alloc_addr != 3'd0)) begin
      pending_nxt[alloc_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register; cleared at once by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 8'd0;
    end else begin
      pending <= pending_nxt;
    end
  end

`ifdef SEQ_RF_WB_ARB_ROUND_ROBIN_EN
  // Priority pointer: after a grant the other requester gets the next conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end
`endif

  // Operand stall: register 0 never stalls, and a same-cycle write to the
  // operand is forwarded by the register file, so only an outstanding
  // producer with no write this cycle holds the read back.
  always_comb begin
    check_stall0 = 1'b0;
    check_stall1 = 1'b0;
    if (reset_n) begin
      if ((check_addr0 != 3'd0) && !(write_en && (write_addr == check_addr0))) begin
        check_stall0 = pending[check_addr0];
      end
      if ((check_addr1 != 3'd0) && !(write_en && (write_addr == check_addr1))) begin
        check_stall1 = pending[check_addr1];
      end
    end
  end

endmodule

// File: tb/tb_seq_rf_wb_arb_scoreboard.sv
// Bench for seq_rf_wb_arb_scoreboard: directed scenarios plus randomized
// traffic, checked against a behavioural model of the scoreboard/arbiter.
module tb_seq_rf_wb_arb_scoreboard;

`ifdef SEQ_RF_WB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       alloc_en;
  logic [2:0] alloc_addr;
  logic       wb0_val;
  logic       wb0_rdy;
  logic [2:0] wb0_addr;
  logic [7:0] wb0_data;
  logic       wb1_val;
  logic       wb1_rdy;
  logic [2:0] wb1_addr;
  logic [7:0] wb1_data;
  logic       write_en;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic [2:0] check_addr0;
  logic       check_stall0;
  logic [2:0] check_addr1;
  logic       check_stall1;

  logic [15:0] obs;
  assign obs = {wb0_rdy, wb1_rdy, write_en, write_addr, write_data, check_stall0, check_stall1};

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit          m_pend [8];
  int          m_ptr;
  int          e_win;
  logic [2:0]  e_waddr;
  logic [15:0] e_vec;

  seq_rf_wb_arb_scoreboard dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alloc_en     (alloc_en),
    .alloc_addr   (alloc_addr),
    .wb0_val      (wb0_val),
    .wb0_rdy      (wb0_rdy),
    .wb0_addr     (wb0_addr),
    .wb0_data     (wb0_data),
    .wb1_val      (wb1_val),
    .wb1_rdy      (wb1_rdy),
    .wb1_addr     (wb1_addr),
    .wb1_data     (wb1_data),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .check_addr0  (check_addr0),
    .check_stall0 (check_stall0),
    .check_addr1  (check_addr1),
    .check_stall1 (check_stall1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    alloc_en    = 1'b0;
    alloc_addr  = 3'd0;
    wb0_val     = 1'b0;
    wb0_addr    = 3'd0;
    wb0_data    = 8'd0;
    wb1_val     = 1'b0;
    wb1_addr    = 3'd0;
    wb1_data    = 8'd0;
    check_addr0 = 3'd0;
    check_addr1 = 3'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Expected outputs for the inputs currently applied.
  task automatic model_eval();
    logic [7:0] wd;
    logic       we, s0, s1;
    e_win = -1;
    if (reset_n) begin
      if (wb0_val && wb1_val) e_win = RR ? m_ptr : 0;
      else if (wb0_val)       e_win = 0;
      else if (wb1_val)       e_win = 1;
    end
    e_waddr = (e_win == 0) ? wb0_addr : (e_win == 1) ? wb1_addr : 3'd0;
    wd      = (e_win == 0) ? wb0_data : (e_win == 1) ? wb1_data : 8'd0;
    we      = (e_win >= 0) && (e_waddr != 3'd0);
    s0 = reset_n && (check_addr0 != 0) && !(we && e_waddr == check_addr0) && m_pend[check_addr0];
    s1 = reset_n && (check_addr1 != 0) && !(we && e_waddr == check_addr1) && m_pend[check_addr1];
    e_vec = {e_win == 0, e_win == 1, we, e_waddr, wd, s0, s1};
  endtask

  // Apply this cycle's effect to the model (call after model_eval).
  task automatic model_commit();
    if (!reset_n) return;
    if (e_win >= 0) begin
      m_pend[e_waddr] = 1'b0;
      m_ptr = 1 - e_win;
    end
    if (alloc_en && alloc_addr != 3'd0) m_pend[alloc_addr] = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    wb0_val = 1'b1; wb0_addr = 3'd3; wb0_data = 8'hA5;
    wb1_val = 1'b1; wb1_addr = 3'd4; wb1_data = 8'h3C;
    check_addr0 = 3'd3; check_addr1 = 3'd4;
    #1;
    n_tests++;
    if (obs !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 16'h0000);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (obs !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, 16'h0000);
    end
  endtask

  task automatic test_alloc_wb();
    do_reset();
    alloc_en = 1'b1; alloc_addr = 3'd3; check_addr0 = 3'd3;
    #1; model_eval();
    n_tests++;
    if (check_stall0 !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_same_cycle_stall: got %b expected 0", check_stall0);
    end
    model_commit();
    @(negedge clk);
    alloc_en = 1'b0;
    #1; model_eval();
    n_tests++;
    if (check_stall0 !== 1'b1) begin
      n_fail++;
      $display("FAIL alloc_next_cycle_stall: got %b expected 1", check_stall0);
    end
    model_commit();
    @(negedge clk);
    wb1_val = 1'b1; wb1_addr = 3'd3; wb1_data = 8'h5A;
    #1; model_eval();
    n_tests++;
    if ({wb1_rdy, write_en, write_addr, write_data, check_stall0} !== {1'b1, 1'b1, 3'd3, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL wb1_forward: got %b%b %0d %h %b expected 11 3 5a 0",
               wb1_rdy, write_en, write_addr, write_data, check_stall0);
    end
    model_commit();
    @(negedge clk);
    wb1_val = 1'b0;
    #1; model_eval();
    n_tests++;
    if (check_stall0 !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_clears_pending: got %b expected 0", check_stall0);
    end
    model_commit();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_g [4];
    do_reset();
    for (int i = 0; i < 4; i++) exp_g[i] = RR ? ((i % 2 == 0) ? 2'b10 : 2'b01) : 2'b10;
    wb0_val = 1'b1; wb0_addr = 3'd1; wb0_data = 8'h10;
    wb1_val = 1'b1; wb1_addr = 3'd2; wb1_data = 8'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if ({wb0_rdy, wb1_rdy} !== exp_g[i]) begin
        n_fail++;
        $display("FAIL fairness_cycle%0d: got %b expected %b", i, {wb0_rdy, wb1_rdy}, exp_g[i]);
      end
      model_eval(); model_commit();
      @(negedge clk);
      if (wb0_rdy) wb0_data = wb0_data + 8'd1;
    end
    idle_inputs();
  endtask

  task automatic test_reg0();
    wb0_val = 1'b1; wb0_addr = 3'd0; wb0_data = 8'hFF;
    #1; model_eval();
    n_tests++;
    if ({wb0_rdy, write_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL wb_reg0: got rdy=%b we=%b expected rdy=1 we=0", wb0_rdy, write_en);
    end
    model_commit();
    @(negedge clk);
    wb0_val = 1'b0;
    alloc_en = 1'b1; alloc_addr = 3'd0; check_addr1 = 3'd0;
    for (int i = 0; i < 2; i++) begin
      #1; model_eval();
      n_tests++;
      if (check_stall1 !== 1'b0) begin
        n_fail++;
        $display("FAIL alloc_reg0_stall%0d: got %b expected 0", i, check_stall1);
      end
      model_commit();
      @(negedge clk);
      alloc_en = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_alloc_wins();
    alloc_en = 1'b1; alloc_addr = 3'd5;
    wb0_val = 1'b1; wb0_addr = 3'd5; wb0_data = 8'h33;
    check_addr1 = 3'd5;
    #1; model_eval(); model_commit();
    @(negedge clk);
    alloc_en = 1'b0; wb0_val = 1'b0;
    #1; model_eval();
    n_tests++;
    if (check_stall1 !== 1'b1) begin
      n_fail++;
      $display("FAIL alloc_wins: got %b expected 1", check_stall1);
    end
    model_commit();
    @(negedge clk);
    wb1_val = 1'b1; wb1_addr = 3'd5; wb1_data = 8'h44;
    #1; model_eval(); model_commit();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    alloc_en = 1'b1; alloc_addr = 3'd2;
    #1; model_eval(); model_commit();
    @(negedge clk);
    alloc_addr = 3'd6;
    wb0_val = 1'b1; wb0_addr = 3'd1; wb0_data = 8'h01;
    #1; model_eval(); model_commit();
    @(negedge clk);
    alloc_en = 1'b0;
    wb0_addr = 3'd2; wb0_data = 8'h77;
    check_addr0 = 3'd2; check_addr1 = 3'd6;
    #1;
    n_tests++;
    if ({wb0_rdy, write_en, check_stall1} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset: got %b expected 111", {wb0_rdy, write_en, check_stall1});
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({wb0_rdy, wb1_rdy, write_en, check_stall0, check_stall1} !== 5'b00000) begin
      n_fail++;
      $display("FAIL mid_cycle_reset: got %b expected 00000",
               {wb0_rdy, wb1_rdy, write_en, check_stall0, check_stall1});
    end
    @(negedge clk);
    reset_n = 1'b1;
    wb0_addr = 3'd3; wb0_data = 8'h88;
    wb1_val = 1'b1; wb1_addr = 3'd4; wb1_data = 8'h99;
    #1; model_eval();
    n_tests++;
    if ({wb0_rdy, wb1_rdy, check_stall0, check_stall1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL post_reset: got %b expected 1000",
               {wb0_rdy, wb1_rdy, check_stall0, check_stall1});
    end
    model_commit();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_nonpending();
    wb1_val = 1'b1; wb1_addr = 3'd4; wb1_data = 8'h11;
    check_addr0 = 3'd4;
    #1; model_eval();
    n_tests++;
    if ({wb1_rdy, write_en, write_addr, write_data, check_stall0} !== {1'b1, 1'b1, 3'd4, 8'h11, 1'b0}) begin
      n_fail++;
      $display("FAIL wb_nonpending: got %b%b %0d %h %b expected 11 4 11 0",
               wb1_rdy, write_en, write_addr, write_data, check_stall0);
    end
    model_commit();
    @(negedge clk);
    wb1_val = 1'b0;
    #1; model_eval();
    n_tests++;
    if (check_stall0 !== 1'b0) begin
      n_fail++;
      $display("FAIL nonpending_after: got %b expected 0", check_stall0);
    end
    model_commit();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    e_win = -1;
    for (int c = 0; c < 400; c++) begin
      // Requesters hold their transaction until accepted.
      if (!(wb0_val && e_win != 0)) begin
        wb0_val  = ($urandom_range(0, 3) != 0);
        wb0_addr = 3'($urandom_range(0, 7));
        wb0_data = 8'($urandom_range(0, 255));
      end
      if (!(wb1_val && e_win != 1)) begin
        wb1_val  = ($urandom_range(0, 3) != 0);
        wb1_addr = 3'($urandom_range(0, 7));
        wb1_data = 8'($urandom_range(0, 255));
      end
      alloc_en    = ($urandom_range(0, 1) == 1);
      alloc_addr  = 3'($urandom_range(0, 7));
      check_addr0 = 3'($urandom_range(0, 7));
      check_addr1 = 3'($urandom_range(0, 7));
      #1; model_eval();
      n_tests++;
      if (obs !== e_vec) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle%0d: got %h expected %h", c, obs, e_vec);
      end
      model_commit();
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alloc_wb();
    test_fairness();
    test_reg0();
    test_alloc_wins();
    test_async_reset();
    test_nonpending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_rf_wb_arb_scoreboard.md
# seq_rf_wb_arb_scoreboard

Writeback arbiter and register scoreboard for the 8-entry x 8-bit, 2-read/1-write register file with write forwarding and hardwired-zero register 0. Two writeback requesters share the register file's single write port through a val/rdy handshake. A per-register pending-bit scoreboard tells the two read ports whether their operand is still awaiting a producer. The block sits between the issue/writeback logic and the register file. It drives the register file's write_en/write_addr/write_data directly.

## Interface
- No parameters; widths fixed: 8 registers (3-bit address), 8-bit data.
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- alloc_en  in  1  reserve a destination register this cycle
- alloc_addr  in  3  register being reserved
- wb0_val  in  1  requester 0 has a writeback
- wb0_rdy  out  1  requester 0 writeback accepted this cycle
- wb0_addr  in  3  requester 0 destination
- wb0_data  in  8  requester 0 data
- wb1_val / wb1_rdy / wb1_addr / wb1_data  same as requester 0, for requester 1
- write_en  out  1  to register file write port
- write_addr  out  3  to register file write port
- write_data  out  8  to register file write port
- check_addr0  in  3  operand address, read port 0
- check_stall0  out  1  operand 0 not yet available
- check_addr1  in  3  operand address, read port 1
- check_stall1  out  1  operand 1 not yet available

## Operation
- State:
  - pending[7:0]: one bit per register; pending[0] is hardwired to 0.
  - ptr: 1 bit; the requester with priority on a conflict.
- Arbitration (combinational):
  - Only one wbN_val high: that requester is granted.
  - Both high: requester ptr is granted.
  - Neither high: no grant.
  - wbN_rdy = grantN. A transfer occurs when val && rdy.
  - A requester holds val, addr and data stable until it sees rdy.
  - rdy may depend on the other requester's val.
- Write port:
  - On a grant: write_addr/write_data = the granted requester's addr/data.
  - write_en = 1 only if the granted addr != 0.
  - A writeback to register 0 is accepted (rdy=1) but never writes.
  - With no grant: write_en=0, and write_addr/write_data are 0.
- Scoreboard update (posedge):
  - On a granted writeback to addr A: pending[A] <= 0.
  - On alloc_en to addr B != 0: pending[B] <= 1.
  - If A == B in the same cycle, alloc wins and the bit ends at 1.
  - alloc to register 0 is ignored.
  - alloc to an already-pending register leaves the bit at 1; it is a single bit, not a count.
  - A writeback to a non-pending register is legal: it writes and the bit stays 0.
- Stall (combinational), per read port N:
  - check_stallN = 0 if check_addrN == 0.
  - Otherwise, check_stallN = 0 if write_en && write_addr == check_addrN. The register file forwards same-cycle write data, so the operand is available.
  - Otherwise, check_stallN = pending[check_addrN].
- Pointer update (posedge): on any grant, ptr <= ~granted_index; ptr holds when there is no grant.

## Timing
- Grant, rdy, write-port outputs and stall outputs are combinational in the same cycle as their inputs. No internal latency.
- Data written on cycle N is visible:
  - in cycle N through register-file forwarding;
  - from cycle N+1 through storage.
- Scoreboard changes from cycle N are visible on check_stall in cycle N+1.
  - alloc in cycle N: a read of that register stalls from N+1.
  - alloc in the same cycle as a read of that register: the read does not stall in that cycle.
- Reset (asynchronous, may assert mid-operation):
  - pending <= 0 and ptr <= 0 immediately.
  - While reset_n=0: wb0_rdy=wb1_rdy=0, write_en=0, check_stall0=check_stall1=0.
  - Any in-flight writeback is simply not accepted. The requester keeps val high and retries after reset deasserts.
- Fairness (round-robin build): with both requesters continuously valid, grants alternate every cycle. No requester waits more than 1 cycle.

## Configuration
- Macro: SEQ_RF_WB_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration using ptr, as described above.
- Undefined: fixed priority; requester 0 always wins a conflict.
  - The ptr register is not implemented.
  - Requester 1 may starve while wb0_val stays high.
- Scoreboard, forwarding-aware stall and reset behaviour are identical in both builds.

## Test plan
- Reset then alloc r3 -> check_addr0=3 stalls from the next cycle. wb1 to r3 with 0x5A -> write_en=1, addr 3, data 0x5A. check_stall0=0 in that same cycle; pending[3]=0 afterwards.
- Both wb valid every cycle for 4 cycles, out of reset (round-robin build) -> grant order 0,1,0,1. Fixed-priority build -> grant order 0,0,0,0 with wb1_rdy=0 throughout.
- wb0 to r0 with data 0xFF -> wb0_rdy=1, write_en=0. alloc r0 -> check_addr1=0 never stalls.
- Same cycle: alloc r5 and a granted wb to r5 -> the next cycle, check_addr1=5 stalls (alloc wins).
- Alloc r2 and r6, then reset_n pulsed low mid-cycle while wb0_val is high -> rdy and write_en drop immediately. After release, r2 and r6 do not stall and ptr=0.
- Writeback to a non-pending r4 with 0x11 -> accepted, write_en=1, no stall change.
